// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - fixed-wait-state asynchronous SRAM responder for the SLC-3 memory interface
module sram_responder #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic [15:0]       ADDR,
    inout  wire  [15:0]       Data,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [15:0]       sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("sram_responder: WAIT_STATES must be in 1..15");
    end
    if (ADDR_W < 16) begin : g_bad_addr_w
        $error("sram_responder: ADDR_W must be at least 16");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q;
    logic        we_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;

    logic ce_n_q, oe_n_q, we_n_q, bs_n_q, dq_oe_q;
    logic ce_n_d, oe_n_d, we_n_d, bs_n_d, dq_oe_d;

    // Strobes are flops loaded from the next-state decode so the pins never glitch.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            bs_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            bs_n_q  <= bs_n_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_en) begin
                    cnt_d   = CNT_INIT;
                    state_d = mem_we ? WRITE : READ;
                end
            end
            READ, WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!mem_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // DONE after a write keeps CE and the data drivers on for one hold cycle past the WE rise.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        bs_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        case (state_d)
            READ: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                bs_n_d = 1'b0;
            end
            WRITE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                bs_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            DONE: begin
                if (we_q) begin
                    ce_n_d  = 1'b0;
                    bs_n_d  = 1'b0;
                    dq_oe_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_q  <= 16'h0000;
            we_q    <= 1'b0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            if (state_q == IDLE && mem_en) begin
                addr_q <= ADDR;
                we_q   <= mem_we;
                if (mem_we) begin
                    wdata_q <= Data;
                end
            end
            if (state_q == READ && cnt_q == 4'd0) begin
                rdata_q <= sram_dq;
            end
        end
    end

    // Ready and the bus driver follow mem_en combinationally so the bus frees the cycle the request drops.
    logic data_oe;
    assign data_oe   = (state_q == DONE) && mem_en && !we_q;
    assign mem_ready = (state_q == DONE) && mem_en;
    assign Data      = data_oe ? rdata_q : 16'hzzzz;

    assign sram_dq   = dq_oe_q ? wdata_q : 16'hzzzz;
    assign sram_addr = ADDR_W'(addr_q);
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_ub_n = bs_n_q;
    assign sram_lb_n = bs_n_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - scoreboard bench for sram_responder with a behavioural asynchronous SRAM
module tb_sram_responder;
    localparam int WS = 2;
    localparam int AW = 20;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          mem_en;
    logic          mem_we;
    logic [15:0]   ADDR;
    logic [15:0]   tb_data;
    logic          tb_data_oe;
    wire  [15:0]   Data;
    wire  [15:0]   sram_dq;
    logic          mem_ready;
    logic [AW-1:0] sram_addr;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic [15:0] sram_mem [0:65535];
    logic [15:0] ref_mem  [0:65535];

    typedef struct {
        bit          we;
        logic [15:0] rdata;
        int          reqc;
    } exp_t;
    exp_t sb_q[$];

    int cycle = 0;
    int n_checks = 0;
    int n_pass = 0;
    int oe_low_cnt = 0;
    int we_low_cnt = 0;
    int acc_cnt = 0;

    sram_responder #(.WAIT_STATES(WS), .ADDR_W(AW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .ADDR      (ADDR),
        .Data      (Data),
        .mem_ready (mem_ready),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cycle <= cycle + 1;

    assign Data    = tb_data_oe ? tb_data : 16'hzzzz;
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr[15:0]] : 16'hzzzz;

    function automatic logic [15:0] init_word(input int a);
        return 16'(a * 7) ^ 16'hC0DE;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cycle);
    endtask

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    function automatic logic [31:0] strobes();
        return 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
    endfunction

    // Asynchronous SRAM: a write commits on the rising edge of WE while CE is still low.
    initial begin
        for (int i = 0; i < 65536; i++) sram_mem[i] = init_word(i);
        sram_mem[16'h1234] = 16'hBEEF;
        forever begin
            @(posedge sram_we_n);
            if (sram_ce_n == 1'b0) sram_mem[sram_addr[15:0]] = sram_dq;
        end
    end

    initial begin
        logic ready_p;
        logic ce_p;
        exp_t e;
        ready_p = 1'b0;
        ce_p    = 1'b1;
        forever begin
            @(negedge Clk);
            if (!sram_oe_n) oe_low_cnt++;
            if (!sram_we_n) we_low_cnt++;
            if (!sram_ce_n && ce_p) acc_cnt++;
            ce_p = sram_ce_n;
            if (mem_ready && !ready_p) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", 32'(mem_ready), 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check("ready_latency", 32'(cycle - e.reqc), 32'(WS));
                    if (!e.we) check("read_data", 32'(Data), 32'(e.rdata));
                end
            end
            ready_p = mem_ready;
        end
    end

    // drop_at = 0: normal access held for `hold` extra cycles; drop_at = n: request falls before edge k+n.
    task automatic do_access(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                             input int hold, input int drop_at);
        exp_t e;
        int   oe0, we0, acc0;
        bit   seen;
        mem_en = 1'b1; mem_we = we; ADDR = addr; tb_data = wd; tb_data_oe = 1'b1;
        oe0 = oe_low_cnt; we0 = we_low_cnt; acc0 = acc_cnt;
        @(posedge Clk);
        #1;
        e.we = we; e.rdata = ref_mem[addr]; e.reqc = cycle;
        if (we) ref_mem[addr] = wd;
        ADDR = 16'($urandom); mem_we = 1'($urandom);
        if (we) tb_data = 16'($urandom);
        else tb_data_oe = 1'b0;
        if (drop_at == 0) begin
            sb_q.push_back(e);
            seen = 1'b0;
            for (int i = 1; i <= 50 && !seen; i++) begin
                step();
                if (!sram_ce_n) check("sram_addr", 32'(sram_addr), 32'(addr));
                if (we && !sram_we_n) check("write_dq", 32'(sram_dq), 32'(wd));
                if (we) check("data_not_driven", 32'(Data), 32'(tb_data));
                if (mem_ready) seen = 1'b1;
            end
            if (!seen) check("ready_timeout", 32'(seen), 32'h1);
            if (we && seen) begin
                check("hold_we_n", 32'(sram_we_n), 32'h1);
                check("hold_ce_n", 32'(sram_ce_n), 32'h0);
                check("hold_dq", 32'(sram_dq), 32'(wd));
            end
            for (int i = 0; i < hold; i++) begin
                step();
                check("ready_held", 32'(mem_ready), 32'h1);
                if (!we) check("read_data_held", 32'(Data), 32'(e.rdata));
            end
            mem_en = 1'b0; tb_data_oe = 1'b1; tb_data = 16'($urandom);
            #1;
            check("ready_release", 32'(mem_ready), 32'h0);
            check("data_release", 32'(Data), 32'(tb_data));
        end else begin
            for (int i = 1; i <= WS + 2; i++) begin
                step();
                if (i == drop_at) begin
                    mem_en = 1'b0; tb_data_oe = 1'b1; tb_data = 16'($urandom);
                end
                if (we && !sram_we_n) check("drop_write_dq", 32'(sram_dq), 32'(wd));
                check("drop_no_ready", 32'(mem_ready), 32'h0);
            end
        end
        step();
        check("idle_strobes", strobes(), 32'h1F);
        check("oe_cycles", 32'(oe_low_cnt - oe0), we ? 32'h0 : 32'(WS));
        check("we_cycles", 32'(we_low_cnt - we0), we ? 32'(WS) : 32'h0);
        check("access_count", 32'(acc_cnt - acc0), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          w;
        logic [15:0] a;
        int          h, d;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
        ref_mem[16'h1234] = 16'hBEEF;

        Reset = 1'b1; mem_en = 1'b0; mem_we = 1'b0; ADDR = 16'h0;
        tb_data = 16'h0; tb_data_oe = 1'b1;
        #2;
        Reset = 1'b0;
        mem_en = 1'($urandom); mem_we = 1'($urandom);
        ADDR = 16'($urandom); tb_data = 16'($urandom);
        #1;
        check("rst_strobes", strobes(), 32'h1F);
        check("rst_ready", 32'(mem_ready), 32'h0);
        check("rst_sram_addr", 32'(sram_addr), 32'h0);
        check("rst_data_free", 32'(Data), 32'(tb_data));
        step();
        step();
        check("rst_strobes_held", strobes(), 32'h1F);
        mem_en = 1'b0;
        Reset = 1'b1;
        step();

        do_access(1'b0, 16'h1234, 16'h0000, 0, 0);
        do_access(1'b1, 16'h0003, 16'h00FF, 0, 0);
        do_access(1'b0, 16'h0003, 16'h0000, 1, 0);
        do_access(1'b1, 16'h0010, 16'hA5A5, 0, 2);
        do_access(1'b0, 16'h0010, 16'h0000, 0, 0);

        mem_en = 1'b1; mem_we = 1'b0; ADDR = 16'h0044; tb_data_oe = 1'b1;
        @(posedge Clk);
        #1;
        tb_data_oe = 1'b0;
        @(posedge Clk);
        #3;
        Reset = 1'b0; mem_en = 1'b0; tb_data_oe = 1'b1; tb_data = 16'($urandom);
        #1;
        check("rst_mid_strobes", strobes(), 32'h1F);
        check("rst_mid_ready", 32'(mem_ready), 32'h0);
        check("rst_mid_data", 32'(Data), 32'(tb_data));
        step();
        Reset = 1'b1;
        do_access(1'b0, 16'h0020, 16'h0000, 0, 0);

        do_access(1'b0, 16'h0040, 16'h0000, 4, 0);

        for (int t = 0; t < 40; t++) begin
            w = 1'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'($urandom);
            else a = 16'h0100 + 16'($urandom_range(0, 7));
            h = int'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) d = int'($urandom_range(1, WS));
            else d = 0;
            do_access(w, a, 16'($urandom), h, d);
        end

        step();
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
